// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its instruction memory, register file and execution unit.
// The master side is the sequencer; the slave side is the memory/regfile/ALU environment.
interface instr_sequencer_if;
   logic [4:0]  imem_addr;
   logic [19:0] imem_data;
   logic [4:0]  addr_a;
   logic [4:0]  addr_b;
   logic [19:0] reg_a_data;
   logic [4:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [19:0] alu_result;
   logic [31:0] reg_we;
   logic [19:0] reg_wdata;

   modport master (
      output imem_addr, addr_a, addr_b, alu_op, alu_start, reg_we, reg_wdata,
      input  imem_data, reg_a_data, alu_done, alu_result
   );

   modport slave (
      input  imem_addr, addr_a, addr_b, alu_op, alu_start, reg_we, reg_wdata,
      output imem_data, reg_a_data, alu_done, alu_result
   );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/write-back controller for the 20-bit, 32-register datapath.
// Control-flow opcodes are resolved in DECODE; all other opcodes are handed to the execution unit.
//
// state     | meaning
// IDLE      | paused at an instruction boundary, waiting for run
// FETCH     | latch imem_data into instr
// DECODE    | resolve NOP/JMP/BEQZ/HALT or start the execution unit
// EXECUTE   | wait for alu_done, bounded by ALU_TIMEOUT cycles
// WRITEBACK | one-cycle register write, pc advances
// HALT      | stopped until reset
module instr_sequencer #(
   parameter logic [4:0] NOP_OP      = 5'h00,
   parameter logic [4:0] BEQZ_OP     = 5'h1D,
   parameter logic [4:0] JMP_OP      = 5'h1E,
   parameter logic [4:0] HALT_OP     = 5'h1F,
   parameter int         ALU_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   instr_sequencer_if.master bus,
   output logic [19:0]       instr,
   output logic [4:0]        pc,
   output logic [2:0]        state,
   output logic              halted,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam int CW = $clog2(ALU_TIMEOUT + 1);

   state_t        st;
   logic [CW-1:0] tmo_cnt;
   logic          alu_start_q;
   logic [31:0]   reg_we_q;
   logic [19:0]   reg_wdata_q;
   logic [4:0]    opcode;
   logic [4:0]    target;

   assign opcode = instr[4:0];
   assign target = instr[19:15];

   assign bus.imem_addr = pc;
   assign bus.addr_a    = instr[9:5];
   assign bus.addr_b    = instr[14:10];
   assign bus.alu_op    = instr[4:0];
   assign bus.alu_start = alu_start_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign state         = st;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st          <= S_IDLE;
         pc          <= '0;
         instr       <= '0;
         tmo_cnt     <= '0;
         alu_start_q <= 1'b0;
         reg_we_q    <= '0;
         reg_wdata_q <= '0;
         halted      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // Pulses default low; only the transitions below raise them for one cycle.
         alu_start_q <= 1'b0;
         reg_we_q    <= '0;
         case (st)
            S_IDLE: begin
               if (run) st <= S_FETCH;
            end
            S_FETCH: begin
               instr <= bus.imem_data;
               st    <= S_DECODE;
            end
            S_DECODE: begin
               st <= run ? S_FETCH : S_IDLE;
               case (opcode)
                  HALT_OP: begin
                     st     <= S_HALT;
                     halted <= 1'b1;
                  end
                  NOP_OP:  pc <= pc + 5'd1;
                  JMP_OP:  pc <= target;
                  BEQZ_OP: pc <= (bus.reg_a_data == 20'd0) ? target : pc + 5'd1;
                  default: begin
                     st          <= S_EXECUTE;
                     alu_start_q <= 1'b1;
                     tmo_cnt     <= '0;
                  end
               endcase
            end
            S_EXECUTE: begin
               if (bus.alu_done) begin
                  reg_wdata_q <= bus.alu_result;
                  reg_we_q    <= 32'd1 << target;
                  st          <= S_WRITEBACK;
               end else if (tmo_cnt == CW'(ALU_TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  halted      <= 1'b1;
                  st          <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_WRITEBACK: begin
               pc <= pc + 5'd1;
               st <= run ? S_FETCH : S_IDLE;
            end
            S_HALT: st <= S_HALT;
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: memory/regfile/ALU models plus a write scoreboard.
module tb_instr_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [19:0] instr;
   logic [4:0]  pc;
   logic [2:0]  state;
   logic        halted;
   logic        timeout_err;

   instr_sequencer_if bus ();

   instr_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .bus         (bus.master),
      .instr       (instr),
      .pc          (pc),
      .state       (state),
      .halted      (halted),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   logic [19:0] mem [32];
   logic [19:0] reg_a_val = 20'd0;
   logic        alu_en = 1'b0;
   logic        force_done = 1'b0;
   logic [19:0] alu_res = 20'd0;
   int          exec_cnt = 0;

   assign bus.imem_data  = mem[bus.imem_addr];
   assign bus.reg_a_data = reg_a_val;
   assign bus.alu_result = alu_res;
   assign bus.alu_done   = force_done || (alu_en && state == 3'd3);

   always @(posedge clk) exec_cnt <= (state == 3'd3) ? exec_cnt + 1 : 0;

   int vectors = 0;
   int miscompares = 0;
   logic [24:0] exp_q [$];

   // Scoreboard: every register write must match the next expected {index, data}.
   always @(negedge clk) begin
      if (bus.reg_we !== 32'd0) begin
         logic [24:0] e;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write reg_we=%h wdata=%h state=%0d", bus.reg_we, bus.reg_wdata, state);
         end else begin
            e = exp_q.pop_front();
            if (bus.reg_we !== (32'd1 << e[24:20]) || bus.reg_wdata !== e[19:0] || state !== 3'd4) begin
               miscompares++;
               $display("FAIL write reg_we=%h wdata=%h state=%0d expected reg_we=%h wdata=%h state=4",
                        bus.reg_we, bus.reg_wdata, state, 32'd1 << e[24:20], e[19:0]);
            end
         end
      end
   end

   function automatic logic [19:0] mk(input logic [4:0] w, input logic [4:0] b,
                                      input logic [4:0] a, input logic [4:0] op);
      return {w, b, a, op};
   endfunction

   task automatic wait_cond(input logic [2:0] s, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (state === s) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_reset();
      run = 1'b0; alu_en = 1'b0; force_done = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic fill_mem(input logic [19:0] v);
      for (int i = 0; i < 32; i++) mem[i] = v;
   endtask

   task automatic test_reset();
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h1F));
      do_reset();
      vectors++;
      if (state !== 3'd0 || pc !== 5'd0 || instr !== 20'd0 || halted !== 1'b0 || timeout_err !== 1'b0 ||
          bus.alu_start !== 1'b0 || bus.reg_we !== 32'd0 || bus.reg_wdata !== 20'd0) begin
         miscompares++;
         $display("FAIL reset state=%0d pc=%0d instr=%h halted=%b terr=%b start=%b we=%h wd=%h expected all zero",
                  state, pc, instr, halted, timeout_err, bus.alu_start, bus.reg_we, bus.reg_wdata);
      end
   endtask

   task automatic test_alu_op();
      logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
      logic       exp_go [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h1F));
      mem[0] = mk(5'd3, 5'd2, 5'd1, 5'h01);
      do_reset();
      alu_en = 1'b1; alu_res = 20'hABCDE;
      exp_q.push_back({5'd3, 20'hABCDE});
      run = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (state !== exp_st[c] || bus.alu_start !== exp_go[c]) begin
            miscompares++;
            $display("FAIL alu_seq cycle=%0d state=%0d start=%b expected state=%0d start=%b",
                     c, state, bus.alu_start, exp_st[c], exp_go[c]);
         end
         if (c == 4) begin
            vectors++;
            if (pc !== 5'd1 || bus.imem_addr !== 5'd1) begin
               miscompares++;
               $display("FAIL alu_pc pc=%0d imem_addr=%0d expected 1", pc, bus.imem_addr);
            end
         end
      end
      alu_en = 1'b0;
   endtask

   task automatic test_jmp_halt();
      bit ok;
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h00));
      mem[0] = mk(5'd7, 5'd0, 5'd0, 5'h1E);
      mem[7] = mk(5'd0, 5'd0, 5'd0, 5'h1F);
      do_reset();
      run = 1'b1;
      wait_cond(3'd5, 20, ok);
      vectors++;
      if (!ok || pc !== 5'd7 || halted !== 1'b1) begin
         miscompares++;
         $display("FAIL jmp_halt reached=%b pc=%0d halted=%b expected reached=1 pc=7 halted=1", ok, pc, halted);
      end
      run = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 10) run = 1'b1;
         vectors++;
         if (state !== 3'd5 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_hold cycle=%0d state=%0d halted=%b expected 5/1", c, state, halted);
         end
      end
   endtask

   task automatic test_beqz(input logic [19:0] a_val, input logic [4:0] exp_pc);
      bit ok;
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h1F));
      mem[0] = mk(5'd2, 5'd0, 5'd0, 5'h1E);
      mem[2] = mk(5'd10, 5'd0, 5'd4, 5'h1D);
      do_reset();
      reg_a_val = a_val;
      run = 1'b1;
      wait_cond(3'd5, 30, ok);
      vectors++;
      if (!ok || pc !== exp_pc) begin
         miscompares++;
         $display("FAIL beqz a=%h reached=%b pc=%0d expected pc=%0d", a_val, ok, pc, exp_pc);
      end
      reg_a_val = 20'd0;
   endtask

   task automatic test_timeout();
      int n = 0;
      bit done = 1'b0;
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h1F));
      mem[0] = mk(5'd5, 5'd0, 5'd0, 5'h02);
      do_reset();
      run = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (state === 3'd3) n++;
         if (state === 3'd5) done = 1'b1;
      end
      vectors++;
      if (!done || n != 16 || timeout_err !== 1'b1 || halted !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout halted=%b exec_cycles=%0d terr=%b expected halted 16 cycles terr=1",
                  done, n, timeout_err);
      end
   endtask

   task automatic test_wrap_pause();
      bit ok = 1'b0;
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h00));
      do_reset();
      run = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = (pc === 5'd31); end
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); ok = (pc === 5'd0); end
      vectors++;
      if (!ok || bus.imem_addr !== 5'd0) begin
         miscompares++;
         $display("FAIL wrap reached=%b imem_addr=%0d expected 0", ok, bus.imem_addr);
      end
      ok = 1'b0;
      for (int c = 0; c < 30 && !ok; c++) begin @(negedge clk); ok = (state === 3'd2 && pc === 5'd5); end
      run = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if (!ok || state !== 3'd0 || pc !== 5'd6) begin
            miscompares++;
            $display("FAIL pause cycle=%0d state=%0d pc=%0d expected state=0 pc=6", c, state, pc);
         end
      end
      run = 1'b1;
      @(negedge clk);
      vectors++;
      if (state !== 3'd1 || bus.imem_addr !== 5'd6) begin
         miscompares++;
         $display("FAIL resume state=%0d imem_addr=%0d expected 1/6", state, bus.imem_addr);
      end
      run = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      bit ok;
      fill_mem(mk(5'd0, 5'd0, 5'd0, 5'h1F));
      mem[0] = mk(5'd4, 5'd0, 5'd0, 5'h03);
      do_reset();
      run = 1'b1;
      wait_cond(3'd3, 10, ok);
      @(negedge clk); @(negedge clk);
      vectors++;
      if (!ok || state !== 3'd3) begin
         miscompares++;
         $display("FAIL stall_setup state=%0d expected 3", state);
      end
      rst_n = 1'b0; run = 1'b0;
      force_done = 1'b1; alu_res = 20'h12345;
      @(negedge clk);
      vectors++;
      if (state !== 3'd0 || pc !== 5'd0 || instr !== 20'd0 || halted !== 1'b0 || timeout_err !== 1'b0 ||
          bus.alu_start !== 1'b0 || bus.reg_we !== 32'd0 || bus.reg_wdata !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_mid state=%0d pc=%0d instr=%h we=%h wd=%h expected all zero",
                  state, pc, instr, bus.reg_we, bus.reg_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk); force_done = 1'b0;
      for (int c = 0; c < 4; c++) @(negedge clk);
      vectors++;
      if (state !== 3'd0 || pc !== 5'd0) begin
         miscompares++;
         $display("FAIL post_reset state=%0d pc=%0d expected 0/0", state, pc);
      end
   endtask

   initial begin
      fill_mem(20'd0);
      test_reset();
      test_alu_op();
      test_jmp_halt();
      test_beqz(20'h00000, 5'd10);
      test_beqz(20'h00001, 5'd3);
      test_timeout();
      test_wrap_pause();
      test_reset_mid_exec();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_writes outstanding=%0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
